// File: rtl/sdram_cmd_issuer_if.sv
// Host/SDRAM-side signal bundle for sdram_cmd_issuer.
// RD_VALID is present only when SDR_RD_VALID_EN is defined.
`timescale 1ns/1ps
interface sdram_cmd_issuer_if #(
    parameter int ASIZE = 23
);
    logic             READA;
    logic             WRITEA;
    logic             REFRESH;
    logic             PRECHARGE;
    logic             LOAD_MODE;
    logic             REF_REQ;
    logic             INIT_REQ;
    logic [ASIZE-1:0] SADDR;
    logic             CM_ACK;
    logic             REF_ACK;
    logic             INIT_ACK;
    logic [11:0]      SA;
    logic [1:0]       BA;
    logic             CS_N;
    logic             RAS_N;
    logic             CAS_N;
    logic             WE_N;
    logic             CKE;
    logic             OE;
`ifdef SDR_RD_VALID_EN
    logic             RD_VALID;
`endif

    modport slave (
        input  READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE, REF_REQ, INIT_REQ, SADDR,
        output CM_ACK, REF_ACK, INIT_ACK, SA, BA, CS_N, RAS_N, CAS_N, WE_N, CKE, OE
`ifdef SDR_RD_VALID_EN
        , output RD_VALID
`endif
    );

    modport master (
        output READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE, REF_REQ, INIT_REQ, SADDR,
        input  CM_ACK, REF_ACK, INIT_ACK, SA, BA, CS_N, RAS_N, CAS_N, WE_N, CKE, OE
`ifdef SDR_RD_VALID_EN
        , input RD_VALID
`endif
    );
endinterface

// File: rtl/sdram_cmd_issuer.sv
// SDRAM command issuer: arbitrates init/refresh/read/write requests and drives timed bus commands.
// Optional macro SDR_RD_VALID_EN adds the RD_VALID read-data window output.
`timescale 1ns/1ps
module sdram_cmd_issuer #(
    parameter int ASIZE     = 23,
    parameter int ROWSIZE   = 12,
    parameter int COLSIZE   = 8,
    parameter int ROWSTART  = 8,
    parameter int COLSTART  = 0,
    parameter int BANKSTART = 20,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int T_RFC     = 7,
    parameter int CAS_LAT   = 3,
    parameter int BURST     = 8
) (
    input  logic                CLK,
    input  logic                RESET_N,
    sdram_cmd_issuer_if.slave   bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_RCD, S_RW, S_DATA, S_PRE, S_REF, S_LMR, S_WAIT
    } state_t;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    localparam int TRCD_E  = (T_RCD   < 1) ? 1 : T_RCD;
    localparam int TRP_E   = (T_RP    < 1) ? 1 : T_RP;
    localparam int TRFC_E  = (T_RFC   < 1) ? 1 : T_RFC;
    localparam int CL_E    = (CAS_LAT < 1) ? 1 : CAS_LAT;
    localparam int BURST_E = (BURST   < 1) ? 1 : BURST;

    // Counter preload for an N-cycle wait; a zero-length wait still costs one cycle.
    function automatic logic [7:0] ld8(input int n);
        return (n <= 1) ? 8'd0 : 8'(n - 1);
    endfunction

    localparam logic [7:0] RCD_LD = ld8(TRCD_E - 1);
    localparam logic [7:0] RP_LD  = ld8(TRP_E);
    localparam logic [7:0] RFC_LD = ld8(TRFC_E);
    localparam logic [7:0] LMR_LD = ld8(2);
    localparam logic [7:0] WR_LD  = ld8(BURST_E - 1 + TRP_E);
    localparam logic [7:0] RD_LD  = ld8(CL_E + BURST_E + TRP_E - 1);
    localparam logic [7:0] TRP_8  = 8'(TRP_E);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             pend_pre_q, pend_pre_d, pend_ref_q, pend_ref_d, pend_lmr_q, pend_lmr_d;
    logic             take_pre_s, take_ref_s, take_lmr_s;
    logic             ref_src_q, ref_src_d, wr_q, wr_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [11:0]      sa_q, sa_d;
    logic [1:0]       ba_q, ba_d;
    logic             cke_q, cke_d, oe_q, oe_d;
    logic             cm_ack_q, cm_ack_d, ref_ack_q, ref_ack_d, init_ack_q, init_ack_d;
    logic [11:0]      row_ext_s, col_ext_s;
    logic [1:0]       bank_s;

    // Zero-extend the latched row/column fields to the 12-bit bus address.
    always_comb begin
        row_ext_s = 12'd0;
        col_ext_s = 12'd0;
        row_ext_s[ROWSIZE-1:0] = addr_q[ROWSTART +: ROWSIZE];
        col_ext_s[COLSIZE-1:0] = addr_q[COLSTART +: COLSIZE];
        bank_s = addr_q[BANKSTART +: 2];
    end

    // Next-state, counters, pending flags and next bus outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ref_src_d  = ref_src_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        cmd_d      = CMD_NOP;
        sa_d       = sa_q;
        ba_d       = ba_q;
        cke_d      = 1'b1;
        oe_d       = 1'b0;
        cm_ack_d   = 1'b0;
        ref_ack_d  = 1'b0;
        init_ack_d = bus.INIT_REQ && (state_q == S_IDLE);
        take_pre_s = 1'b0;
        take_ref_s = 1'b0;
        take_lmr_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_lmr_q) begin
                    take_lmr_s = 1'b1;
                    addr_d     = bus.SADDR;
                    state_d    = S_LMR;
                end else if (pend_pre_q) begin
                    take_pre_s = 1'b1;
                    state_d    = S_PRE;
                end else if (pend_ref_q) begin
                    take_ref_s = 1'b1;
                    ref_src_d  = 1'b0;
                    state_d    = S_REF;
                end else if (!bus.INIT_REQ && bus.REF_REQ) begin
                    ref_src_d  = 1'b1;
                    state_d    = S_REF;
                end else if (!bus.INIT_REQ && (bus.READA || bus.WRITEA)) begin
                    wr_d       = !bus.READA;
                    addr_d     = bus.SADDR;
                    cm_ack_d   = 1'b1;
                    state_d    = S_ACT;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_ACT: begin
                cmd_d   = CMD_ACT;
                sa_d    = row_ext_s;
                ba_d    = bank_s;
                cnt_d   = RCD_LD;
                state_d = S_RCD;
            end
            S_RCD: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_RW;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RW: begin
                cmd_d      = wr_q ? CMD_WR : CMD_RD;
                sa_d       = col_ext_s;
                sa_d[10]   = 1'b1;
                ba_d       = bank_s;
                oe_d       = wr_q;
                cnt_d      = wr_q ? WR_LD : RD_LD;
                state_d    = S_DATA;
            end
            S_DATA: begin
                // Remaining count above the recovery tail means the burst is still being driven.
                oe_d = wr_q && (cnt_q >= TRP_8);
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PRE: begin
                cmd_d   = CMD_PRE;
                sa_d    = 12'h400;
                ba_d    = 2'd0;
                cnt_d   = RP_LD;
                state_d = S_WAIT;
            end
            S_REF: begin
                cmd_d     = CMD_REF;
                ref_ack_d = ref_src_q;
                cnt_d     = RFC_LD;
                state_d   = S_WAIT;
            end
            S_LMR: begin
                cmd_d   = CMD_LMR;
                sa_d    = addr_q[11:0];
                ba_d    = 2'd0;
                cnt_d   = LMR_LD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        // A pulse arriving while its type is already pending is dropped.
        pend_pre_d = (pend_pre_q && !take_pre_s) || (bus.PRECHARGE && !pend_pre_q);
        pend_ref_d = (pend_ref_q && !take_ref_s) || (bus.REFRESH   && !pend_ref_q);
        pend_lmr_d = (pend_lmr_q && !take_lmr_s) || (bus.LOAD_MODE && !pend_lmr_q);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            pend_pre_q <= 1'b0;
            pend_ref_q <= 1'b0;
            pend_lmr_q <= 1'b0;
            ref_src_q  <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            cmd_q      <= CMD_NOP;
            sa_q       <= 12'd0;
            ba_q       <= 2'd0;
            cke_q      <= 1'b0;
            oe_q       <= 1'b0;
            cm_ack_q   <= 1'b0;
            ref_ack_q  <= 1'b0;
            init_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_pre_q <= pend_pre_d;
            pend_ref_q <= pend_ref_d;
            pend_lmr_q <= pend_lmr_d;
            ref_src_q  <= ref_src_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            sa_q       <= sa_d;
            ba_q       <= ba_d;
            cke_q      <= cke_d;
            oe_q       <= oe_d;
            cm_ack_q   <= cm_ack_d;
            ref_ack_q  <= ref_ack_d;
            init_ack_q <= init_ack_d;
        end
    end

    assign bus.CS_N     = cmd_q[3];
    assign bus.RAS_N    = cmd_q[2];
    assign bus.CAS_N    = cmd_q[1];
    assign bus.WE_N     = cmd_q[0];
    assign bus.SA       = sa_q;
    assign bus.BA       = ba_q;
    assign bus.CKE      = cke_q;
    assign bus.OE       = oe_q;
    assign bus.CM_ACK   = cm_ack_q;
    assign bus.REF_ACK  = ref_ack_q;
    assign bus.INIT_ACK = init_ack_q;

`ifdef SDR_RD_VALID_EN
    localparam logic [7:0] BURST_LD = ld8(BURST_E);

    logic [CL_E-1:0] lat_q, lat_d;
    logic [7:0]      beat_q, beat_d;
    logic            rd_valid_q, rd_valid_d;

    // READ issue travels down the latency line, then opens a BURST-long window.
    always_comb begin
        lat_d    = lat_q << 1'b1;
        lat_d[0] = (state_q == S_RW) && !wr_q;
        if (lat_q[CL_E-1]) begin
            rd_valid_d = 1'b1;
            beat_d     = BURST_LD;
        end else if (beat_q != 8'd0) begin
            rd_valid_d = 1'b1;
            beat_d     = beat_q - 8'd1;
        end else begin
            rd_valid_d = 1'b0;
            beat_d     = beat_q;
        end
    end

    // Read-valid pipeline registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lat_q      <= '0;
            beat_q     <= 8'd0;
            rd_valid_q <= 1'b0;
        end else begin
            lat_q      <= lat_d;
            beat_q     <= beat_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.RD_VALID = rd_valid_q;
`endif
endmodule
